// File: rtl/shift_sub_div_pkg.sv
// -----------------------------------------------------------------------------
// shift_sub_div_pkg
// Shared definitions for the restoring shift-subtract divider:
//   - state_t      : FSM state encoding (IDLE, RUN, FIN)
//   - DEFAULT_N    : default operand width
//   - clog2()      : width of the iteration counter for an n-bit divide
// -----------------------------------------------------------------------------
package shift_sub_div_pkg;

   localparam int unsigned DEFAULT_N = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int unsigned value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/shift_sub_div_step.sv
// -----------------------------------------------------------------------------
// shift_sub_div_step
// One combinational restoring-division iteration.
// Ports:
//   rem_acc  [n:0]   in   partial remainder before this iteration
//   q_acc    [n-1:0] in   dividend/quotient shift register before this iteration
//   divisor  [n-1:0] in   divisor magnitude
//   rem_next [n:0]   out  partial remainder after this iteration
//   q_next   [n-1:0] out  shift register after this iteration (new LSB = quotient bit)
// -----------------------------------------------------------------------------
module shift_sub_div_step
   import shift_sub_div_pkg::*;
#(
   parameter int unsigned n = DEFAULT_N
) (
   input  logic [n:0]   rem_acc,
   input  logic [n-1:0] q_acc,
   input  logic [n-1:0] divisor,
   output logic [n:0]   rem_next,
   output logic [n-1:0] q_next
);

   // The shifted value keeps the accumulator's top bit, so one extra bit
   // makes the borrow test exact for any accumulator contents.
   logic [n+1:0] shifted_s;
   logic [n+1:0] trial_s;

   // Shift in the next dividend bit, trial-subtract, restore on borrow.
   always_comb begin
      shifted_s = {rem_acc, q_acc[n-1]};
      trial_s   = shifted_s - {2'b00, divisor};
      if (trial_s[n+1] == 1'b0) begin
         rem_next = trial_s[n:0];
         q_next   = {q_acc[n-2:0], 1'b1};
      end else begin
         rem_next = shifted_s[n:0];
         q_next   = {q_acc[n-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/shift_sub_divide.sv
// -----------------------------------------------------------------------------
// shift_sub_divide
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Build option: define SHIFT_SUB_DIV_SIGNED_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset (aborts a running divide)
//   start        in   request; accepted only in IDLE
//   dividend     in   numerator, captured on accepted start
//   divisor      in   denominator, captured on accepted start
//   busy         out  high while iterating
//   done         out  one-cycle pulse with valid results
//   quotient     out  result quotient, held until the next result
//   remainder    out  result remainder, held until the next result
//   div_by_zero  out  captured divisor was zero; clears on next accepted start
// -----------------------------------------------------------------------------
module shift_sub_divide
   import shift_sub_div_pkg::*;
#(
   parameter int unsigned n = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] quotient,
   output logic [n-1:0] remainder,
   output logic         div_by_zero
);

   localparam int            CW         = clog2(n);
   localparam logic [CW-1:0] COUNT_LOAD = CW'(n - 1);

   state_t        state_r;
   state_t        state_s;
   logic [n:0]    rem_acc_r;
   logic [n:0]    rem_next_s;
   logic [n-1:0]  q_acc_r;
   logic [n-1:0]  q_next_s;
   logic [n-1:0]  divisor_r;
   logic [CW-1:0] count_r;
   logic          busy_r;
   logic          done_r;
   logic          dbz_r;
   logic [n-1:0]  quotient_r;
   logic [n-1:0]  remainder_r;

   logic          zero_div_s;
   logic          last_iter_s;
   logic [n-1:0]  dividend_mag_s;
   logic [n-1:0]  divisor_mag_s;
   logic [n-1:0]  quotient_fix_s;
   logic [n-1:0]  remainder_fix_s;

`ifdef SHIFT_SUB_DIV_SIGNED_EN
   logic neg_q_r;
   logic neg_rem_r;

   function automatic logic [n-1:0] negate(input logic [n-1:0] x);
      return ~x + {{(n-1){1'b0}}, 1'b1};
   endfunction

   // -2^(n-1) maps onto itself, which reads correctly as an unsigned magnitude.
   function automatic logic [n-1:0] magnitude(input logic [n-1:0] x);
      return x[n-1] ? negate(x) : x;
   endfunction
`endif

   shift_sub_div_step #(.n(n)) u_step (
      .rem_acc  (rem_acc_r),
      .q_acc    (q_acc_r),
      .divisor  (divisor_r),
      .rem_next (rem_next_s),
      .q_next   (q_next_s)
   );

   // Decode helpers plus operand magnitudes and result sign fix-up.
   always_comb begin
      zero_div_s  = (divisor == {n{1'b0}});
      last_iter_s = (state_r == RUN) && (count_r == {CW{1'b0}});
`ifdef SHIFT_SUB_DIV_SIGNED_EN
      dividend_mag_s  = magnitude(dividend);
      divisor_mag_s   = magnitude(divisor);
      quotient_fix_s  = neg_q_r   ? negate(q_next_s)          : q_next_s;
      remainder_fix_s = neg_rem_r ? negate(rem_next_s[n-1:0]) : rem_next_s[n-1:0];
`else
      dividend_mag_s  = dividend;
      divisor_mag_s   = divisor;
      quotient_fix_s  = q_next_s;
      remainder_fix_s = rem_next_s[n-1:0];
`endif
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = zero_div_s ? FIN : RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_iter_s) begin
               state_s = FIN;
            end else begin
               state_s = RUN;
            end
         end
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Capture, iteration datapath and registered outputs; results load on the
   // edge that enters FIN so done and the values appear together.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_acc_r   <= {(n+1){1'b0}};
         q_acc_r     <= {n{1'b0}};
         divisor_r   <= {n{1'b0}};
         count_r     <= {CW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         dbz_r       <= 1'b0;
         quotient_r  <= {n{1'b0}};
         remainder_r <= {n{1'b0}};
`ifdef SHIFT_SUB_DIV_SIGNED_EN
         neg_q_r     <= 1'b0;
         neg_rem_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  dbz_r <= zero_div_s;
                  if (zero_div_s) begin
                     quotient_r  <= {n{1'b1}};
                     remainder_r <= dividend;
                     done_r      <= 1'b1;
                  end else begin
                     busy_r    <= 1'b1;
                     rem_acc_r <= {(n+1){1'b0}};
                     q_acc_r   <= dividend_mag_s;
                     divisor_r <= divisor_mag_s;
                     count_r   <= COUNT_LOAD;
`ifdef SHIFT_SUB_DIV_SIGNED_EN
                     neg_q_r   <= dividend[n-1] ^ divisor[n-1];
                     neg_rem_r <= dividend[n-1];
`endif
                  end
               end
            end
            RUN: begin
               rem_acc_r <= rem_next_s;
               q_acc_r   <= q_next_s;
               if (last_iter_s) begin
                  count_r     <= {CW{1'b0}};
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  quotient_r  <= quotient_fix_s;
                  remainder_r <= remainder_fix_s;
               end else begin
                  count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
               end
            end
            FIN: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_shift_sub_divide.sv
// -----------------------------------------------------------------------------
// tb_shift_sub_divide
// Self-checking bench for shift_sub_divide: an 8-bit instance for the directed
// scenarios and a 32-bit instance for random operands. Expected results come
// from plain integer division in ref_div. Honours SHIFT_SUB_DIV_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_shift_sub_divide;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic       rst8, start8, busy8, done8, dbz8;
   logic [7:0] dvd8, dvs8, q8, r8;
   logic        rst32, start32, busy32, done32, dbz32;
   logic [31:0] dvd32, dvs32, q32, r32;

   shift_sub_divide #(.n(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .dividend(dvd8), .divisor(dvs8),
      .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
   );

   shift_sub_divide #(.n(32)) dut32 (
      .clk(clk), .rst(rst32), .start(start32), .dividend(dvd32), .divisor(dvs32),
      .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: integer division on w-bit operands, results truncated to w bits.
   function automatic void ref_div(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                   output logic [31:0] q, output logic [31:0] r, output logic z);
      logic [31:0] mask, a, b;
      longint sa, sb, lq, lr;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      a = a_in & mask;
      b = b_in & mask;
      if (b == 32'd0) begin
         q = mask;
         r = a;
         z = 1'b1;
      end else begin
`ifdef SHIFT_SUB_DIV_SIGNED_EN
         sa = a[w-1] ? ($signed({32'd0, a}) - (64'sd1 <<< w)) : $signed({32'd0, a});
         sb = b[w-1] ? ($signed({32'd0, b}) - (64'sd1 <<< w)) : $signed({32'd0, b});
`else
         sa = $signed({32'd0, a});
         sb = $signed({32'd0, b});
`endif
         lq = sa / sb;
         lr = sa % sb;
         q = lq[31:0] & mask;
         r = lr[31:0] & mask;
         z = 1'b0;
      end
   endfunction

   // Launch one 8-bit divide; returns edges-to-done (start edge counts as 1).
   task automatic div8(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int bcnt, output bit seen);
      dvd8 = a; dvs8 = b; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      dvd8 = 8'($urandom); dvs8 = 8'($urandom);
      lat = 1; bcnt = 0; seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done8) begin
            seen = 1'b1;
            break;
         end
         if (busy8) bcnt++;
         tick;
         lat++;
      end
   endtask

   task automatic div32(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit seen);
      dvd32 = a; dvs32 = b; start32 = 1'b1;
      tick;
      start32 = 1'b0;
      dvd32 = $urandom; dvs32 = $urandom;
      lat = 1; seen = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (done32) begin
            seen = 1'b1;
            break;
         end
         tick;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst8 = 1'b1; start8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;
      rst32 = 1'b1; start32 = 1'b0; dvd32 = 32'd0; dvs32 = 32'd0;
      tick; tick;
      rst8 = 1'b0; rst32 = 1'b0;
      total++;
      if ({busy8, done8, dbz8} !== 3'b000) begin
         bad++; $display("FAIL reset_flags8 got=%b want=000", {busy8, done8, dbz8});
      end
      total++;
      if ({q8, r8} !== 16'h0000) begin
         bad++; $display("FAIL reset_results8 got q=%0d r=%0d want 0 0", q8, r8);
      end
      total++;
      if ({busy32, done32, dbz32, q32, r32} !== 67'd0) begin
         bad++; $display("FAIL reset_32 got busy=%b done=%b dbz=%b q=%0h r=%0h want all 0",
                         busy32, done32, dbz32, q32, r32);
      end
   endtask

   task automatic test_basic;
      logic [31:0] eq, er; logic ez; int lat, bcnt; bit seen;
      ref_div(8, 32'd100, 32'd7, eq, er, ez);
      tick;
      div8(8'd100, 8'd7, lat, bcnt, seen);
      total++;
      if (!seen) begin bad++; $display("FAIL basic_timeout no done within budget"); end
      total++;
      if (lat != 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
      total++;
      if (bcnt != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bcnt); end
      total++;
      if ({q8, r8, dbz8} !== {eq[7:0], er[7:0], ez}) begin
         bad++; $display("FAIL basic_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         q8, r8, dbz8, eq[7:0], er[7:0], ez);
      end
      tick;
      total++;
      if (done8 !== 1'b0 || q8 !== eq[7:0] || r8 !== er[7:0]) begin
         bad++; $display("FAIL basic_hold got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
                         done8, q8, r8, eq[7:0], er[7:0]);
      end
   endtask

   task automatic test_edge_values;
      logic [31:0] eq, er; logic ez; int lat, bcnt; bit seen;
      ref_div(8, 32'd5, 32'd9, eq, er, ez);
      div8(8'd5, 8'd9, lat, bcnt, seen);
      total++;
      if (!seen || {q8, r8} !== {eq[7:0], er[7:0]}) begin
         bad++; $display("FAIL small_over_large got seen=%b q=%0d r=%0d want q=%0d r=%0d",
                         seen, q8, r8, eq[7:0], er[7:0]);
      end
      // Cycle after done: start must be taken straight away.
      tick;
      ref_div(8, 32'd255, 32'd1, eq, er, ez);
      div8(8'd255, 8'd1, lat, bcnt, seen);
      total++;
      if (!seen || lat != 9) begin
         bad++; $display("FAIL back_to_back_latency got seen=%b lat=%0d want lat=9", seen, lat);
      end
      total++;
      if ({q8, r8, dbz8} !== {eq[7:0], er[7:0], ez}) begin
         bad++; $display("FAIL divide_by_one got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         q8, r8, dbz8, eq[7:0], er[7:0], ez);
      end
   endtask

   task automatic test_div_zero;
      logic [31:0] eq, er; logic ez; int lat, bcnt; bit seen;
      tick;
      div8(8'd42, 8'd0, lat, bcnt, seen);
      total++;
      if (!seen || lat != 1 || bcnt != 0) begin
         bad++; $display("FAIL dbz_timing got seen=%b lat=%0d busy=%0d want lat=1 busy=0", seen, lat, bcnt);
      end
      total++;
      if ({q8, r8, dbz8} !== {8'hFF, 8'd42, 1'b1}) begin
         bad++; $display("FAIL dbz_result got q=%0h r=%0d z=%b want q=ff r=42 z=1", q8, r8, dbz8);
      end
      tick;
      total++;
      if (dbz8 !== 1'b1 || done8 !== 1'b0 || q8 !== 8'hFF) begin
         bad++; $display("FAIL dbz_hold got z=%b done=%b q=%0h want z=1 done=0 q=ff", dbz8, done8, q8);
      end
      ref_div(8, 32'd20, 32'd4, eq, er, ez);
      div8(8'd20, 8'd4, lat, bcnt, seen);
      total++;
      if (!seen || {q8, r8, dbz8} !== {eq[7:0], er[7:0], 1'b0}) begin
         bad++; $display("FAIL dbz_clear got seen=%b q=%0d r=%0d z=%b want q=%0d r=%0d z=0",
                         seen, q8, r8, dbz8, eq[7:0], er[7:0]);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] eq, er; logic ez; int lat, bcnt, dones; bit seen;
      tick;
      dvd8 = 8'd200; dvs8 = 8'd3; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      for (int k = 0; k < 4; k++) tick;
      rst8 = 1'b1;
      tick;
      rst8 = 1'b0;
      total++;
      if ({busy8, done8, dbz8, q8, r8} !== 19'd0) begin
         bad++; $display("FAIL midreset_clear got busy=%b done=%b z=%b q=%0d r=%0d want all 0",
                         busy8, done8, dbz8, q8, r8);
      end
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         if (done8) dones++;
         tick;
      end
      total++;
      if (dones != 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", dones); end
      ref_div(8, 32'd200, 32'd3, eq, er, ez);
      div8(8'd200, 8'd3, lat, bcnt, seen);
      total++;
      if (!seen || {q8, r8} !== {eq[7:0], er[7:0]}) begin
         bad++; $display("FAIL midreset_rerun got seen=%b q=%0d r=%0d want q=%0d r=%0d",
                         seen, q8, r8, eq[7:0], er[7:0]);
      end
   endtask

   task automatic test_start_held;
      logic [31:0] eq, er; logic ez; int dones; bit seen;
      ref_div(8, 32'd77, 32'd5, eq, er, ez);
      tick;
      dvd8 = 8'd77; dvs8 = 8'd5; start8 = 1'b1;
      tick;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done8) begin
            seen = 1'b1;
            break;
         end
         dvd8 = 8'($urandom); dvs8 = 8'($urandom);
         tick;
      end
      total++;
      if (!seen || {q8, r8} !== {eq[7:0], er[7:0]}) begin
         bad++; $display("FAIL held_start_result got seen=%b q=%0d r=%0d want q=%0d r=%0d",
                         seen, q8, r8, eq[7:0], er[7:0]);
      end
      // start still high across the FIN cycle edge must not start another run.
      dvs8 = 8'd3;
      tick;
      start8 = 1'b0;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         if (done8 || busy8) dones++;
         tick;
      end
      total++;
      if (dones != 0) begin bad++; $display("FAIL held_start_single_done extra activity=%0d want=0", dones); end
   endtask

   task automatic test_random32;
      logic [31:0] a, b, eq, er; logic ez; int lat; bit seen;
      logic [63:0] recon;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 49) == 0) b = 32'd0;
         ref_div(32, a, b, eq, er, ez);
         tick;
         div32(a, b, lat, seen);
         total++;
         if (!seen || lat != ((b == 32'd0) ? 1 : 33)) begin
            bad++; $display("FAIL rand_latency a=%0h b=%0h got seen=%b lat=%0d", a, b, seen, lat);
         end
         total++;
         if ({q32, r32, dbz32} !== {eq, er, ez}) begin
            bad++; $display("FAIL rand_result a=%0h b=%0h got q=%0h r=%0h z=%b want q=%0h r=%0h z=%b",
                            a, b, q32, r32, dbz32, eq, er, ez);
         end
`ifndef SHIFT_SUB_DIV_SIGNED_EN
         if (b != 32'd0) begin
            recon = {32'd0, q32} * {32'd0, b} + {32'd0, r32};
            total++;
            if (recon !== {32'd0, a} || !(r32 < b)) begin
               bad++; $display("FAIL rand_invariant a=%0h b=%0h got q=%0h r=%0h", a, b, q32, r32);
            end
         end
`endif
      end
   endtask

`ifdef SHIFT_SUB_DIV_SIGNED_EN
   task automatic test_signed;
      logic [7:0] av [3] = '{8'h9C, 8'h64, 8'h80};
      logic [7:0] bv [3] = '{8'h07, 8'hF9, 8'hFF};
      logic [7:0] qv [3] = '{8'hF2, 8'hF2, 8'h80};
      logic [7:0] rv [3] = '{8'hFE, 8'h02, 8'h00};
      int lat, bcnt; bit seen;
      for (int i = 0; i < 3; i++) begin
         tick;
         div8(av[i], bv[i], lat, bcnt, seen);
         total++;
         if (!seen || lat != 9 || {q8, r8} !== {qv[i], rv[i]}) begin
            bad++; $display("FAIL signed_case%0d got seen=%b lat=%0d q=%0h r=%0h want q=%0h r=%0h",
                            i, seen, lat, q8, r8, qv[i], rv[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_edge_values;
      test_div_zero;
      test_reset_mid;
      test_start_held;
`ifdef SHIFT_SUB_DIV_SIGNED_EN
      test_signed;
`endif
      test_random32;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
